// File: rtl/msg_word_packer_pkg.sv
// Shared definitions for the message word packer slice.
//   state_t      : packing FSM states (2-bit encoding)
//   MSG_LAST_BIT : position of the end-of-message flag in a FIFO entry
//   FIFO_W       : FIFO entry width, {last, word[15:0]}
//   pack_entry() : assembles a FIFO entry from its last flag and two bytes
package msg_word_packer_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam int MSG_LAST_BIT = 16;
  localparam int FIFO_W       = 17;

  // Big-endian: the earlier byte of the pair occupies the upper half.
  function automatic logic [FIFO_W-1:0] pack_entry(input logic       last,
                                                   input logic [7:0] hi,
                                                   input logic [7:0] lo);
    return {last, hi, lo};
  endfunction

endpackage

// File: rtl/msg_word_packer_fifo.sv
// sync_fifo_showahead: single-clock show-ahead FIFO.
//   CLK     in   clock
//   RST     in   asynchronous active-low clear of pointers and fill count
//   wr_en   in   push wr_data (ignored while full)
//   wr_data in   W-bit entry to push
//   rd_en   in   pop head entry (ignored while empty)
//   q       out  head entry, valid while !empty
//   usedw   out  number of stored entries, 0..DEPTH
//   empty   out  no entries stored
//   full    out  DEPTH entries stored
// The head is read combinationally from the storage array so it is
// presented without a read request (show-ahead); a pushed entry becomes
// visible on q the cycle after the push.
module sync_fifo_showahead #(
  parameter int W     = 17,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  q,
  output logic [AW:0]   usedw,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage carries no reset so it maps onto RAM.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   usedw <= usedw + (AW+1)'(1);
        2'b01:   usedw <= usedw - (AW+1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end

  assign empty = (usedw == '0);
  assign full  = (usedw == (AW+1)'(DEPTH));
  assign q     = mem[rd_ptr];

endmodule

// File: rtl/msg_word_packer.sv
// msg_word_packer: packs a byte stream into 16-bit words, buffers them in a
// show-ahead FIFO and flags when at least one complete message is buffered.
//   CLK          in   clock
//   RST          in   asynchronous active-low reset
//   IN_DATA      in   source byte
//   IN_VALID     in   IN_DATA valid this cycle (no backpressure)
//   IN_EOM       in   last byte of message, qualified by IN_VALID
//   RD_REQ       in   consume head word; ignored while EMPTY
//   fifo_q       out  head word, valid while !EMPTY
//   GOT_FULL_MSG out  registered, high while a complete message is buffered
//   EMPTY        out  FIFO empty
//   DROP         out  1-cycle pulse: message refused at admission
//   TRUNC        out  1-cycle pulse: message cut at MAX_MSG_WORDS
module msg_word_packer
  import msg_word_packer_pkg::*;
#(
  parameter int         DEPTH         = 1024,
  parameter int         AW            = 10,
  parameter int         MAX_MSG_WORDS = 256,
  parameter logic [7:0] PAD_BYTE      = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  input  logic        IN_EOM,
  input  logic        RD_REQ,
  output logic [15:0] fifo_q,
  output logic        GOT_FULL_MSG,
  output logic        EMPTY,
  output logic        DROP,
  output logic        TRUNC
);

  localparam int              WCW         = $clog2(MAX_MSG_WORDS + 1);
  localparam logic [AW+1:0]   ADMIT_LIMIT = (AW+2)'(DEPTH - MAX_MSG_WORDS);
  localparam logic [WCW-1:0]  WCNT_LAST   = WCW'(MAX_MSG_WORDS - 1);

  state_t              state;
  logic                hi_valid;
  logic [7:0]          hi;
  logic [WCW-1:0]      wcnt;

  logic                vld_p0;
  logic [FIFO_W-1:0]   entry_p0;

  logic [FIFO_W-1:0]   q_entry;
  logic [AW:0]         usedw;
  logic                fifo_full;

  logic [AW:0]         msg_cnt;
  logic [AW:0]         msg_cnt_nxt;

  logic [AW+1:0]       occ;
  logic                admit;
  logic                accept;
  logic                pair;
  logic                odd_end;
  logic                trunc_hit;
  logic                rd_fire;
  logic                msg_inc;
  logic                msg_dec;

  // Occupancy includes the word still sitting in the write register, so a
  // message admitted right behind the previous one cannot overrun the FIFO.
  always_comb begin
    occ       = {1'b0, usedw} + (AW+2)'(vld_p0);
    admit     = (occ <= ADMIT_LIMIT);
    accept    = IN_VALID && ((state == S_COLLECT) || ((state == S_IDLE) && admit));
    pair      = accept && hi_valid;
    odd_end   = accept && !hi_valid && IN_EOM;
    trunc_hit = pair && !IN_EOM && (wcnt == WCNT_LAST);
    rd_fire   = RD_REQ && !EMPTY;
    msg_inc   = vld_p0 && entry_p0[MSG_LAST_BIT];
    msg_dec   = rd_fire && q_entry[MSG_LAST_BIT];
    msg_cnt_nxt = msg_cnt;
    if (msg_inc && !msg_dec) msg_cnt_nxt = msg_cnt + (AW+1)'(1);
    if (msg_dec && !msg_inc) msg_cnt_nxt = msg_cnt - (AW+1)'(1);
  end

  // ---- stage p0: packing FSM and registered write request ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      hi_valid <= 1'b0;
      wcnt     <= '0;
      vld_p0   <= 1'b0;
      DROP     <= 1'b0;
      TRUNC    <= 1'b0;
    end else begin
      vld_p0 <= pair || odd_end;
      DROP   <= IN_VALID && (state == S_IDLE) && !admit;
      TRUNC  <= trunc_hit;
      case (state)
        // An admitted first byte in S_IDLE is handled exactly like a byte in
        // S_COLLECT; accept is only false here for a refused first byte.
        S_IDLE, S_COLLECT: begin
          if (IN_VALID) begin
            if (!accept) begin
              state <= IN_EOM ? S_IDLE : S_DISCARD;
            end else if (!hi_valid) begin
              if (IN_EOM) begin
                state <= S_IDLE;
                wcnt  <= '0;
              end else begin
                state    <= S_COLLECT;
                hi_valid <= 1'b1;
              end
            end else begin
              hi_valid <= 1'b0;
              if (IN_EOM) begin
                state <= S_IDLE;
                wcnt  <= '0;
              end else if (trunc_hit) begin
                state <= S_DISCARD;
                wcnt  <= '0;
              end else begin
                wcnt <= wcnt + WCW'(1);
              end
            end
          end
        end
        S_DISCARD: begin
          if (IN_VALID && IN_EOM) state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          hi_valid <= 1'b0;
          wcnt     <= '0;
        end
      endcase
    end
  end

  // Datapath registers carry no reset; they are qualified by hi_valid/vld_p0.
  always_ff @(posedge CLK) begin
    if (accept && !hi_valid) hi <= IN_DATA;
    entry_p0 <= pair ? pack_entry(IN_EOM || trunc_hit, hi, IN_DATA)
                     : pack_entry(1'b1, IN_DATA, PAD_BYTE);
  end

  // ---- stage p1: FIFO write, complete-message accounting ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      msg_cnt      <= '0;
      GOT_FULL_MSG <= 1'b0;
    end else begin
      msg_cnt      <= msg_cnt_nxt;
      GOT_FULL_MSG <= (msg_cnt_nxt != '0);
    end
  end

  sync_fifo_showahead #(
    .W     (FIFO_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (vld_p0),
    .wr_data (entry_p0),
    .rd_en   (RD_REQ),
    .q       (q_entry),
    .usedw   (usedw),
    .empty   (EMPTY),
    .full    (fifo_full)
  );

  assign fifo_q = q_entry[15:0];

  // Admission control must make a write into a full FIFO impossible.
  assert property (@(posedge CLK) disable iff (!RST) !(vld_p0 && fifo_full));
  assert property (@(posedge CLK) disable iff (!RST)
                   !(msg_dec && !msg_inc && (msg_cnt == '0)));
  assert property (@(posedge CLK) disable iff (!RST)
                   !(msg_inc && !msg_dec && (msg_cnt == (AW+1)'(DEPTH))));

endmodule

// File: tb/tb_msg_word_packer.sv
// Testbench for msg_word_packer: message-level reference model feeding an
// expected-word queue, with a monitor that pops and compares on every read.
module tb_msg_word_packer;

  localparam int         DEPTH = 1024;
  localparam int         AW    = 10;
  localparam int         MAXW  = 256;
  localparam logic [7:0] PAD   = 8'h00;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_VALID = 1'b0;
  logic        IN_EOM = 1'b0;
  logic        RD_REQ = 1'b0;
  logic [15:0] fifo_q;
  logic        GOT_FULL_MSG;
  logic        EMPTY;
  logic        DROP;
  logic        TRUNC;

  msg_word_packer #(
    .DEPTH(DEPTH), .AW(AW), .MAX_MSG_WORDS(MAXW), .PAD_BYTE(PAD)
  ) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_EOM(IN_EOM), .RD_REQ(RD_REQ), .fifo_q(fifo_q),
    .GOT_FULL_MSG(GOT_FULL_MSG), .EMPTY(EMPTY), .DROP(DROP), .TRUNC(TRUNC)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [16:0] exp_q[$];
  int          drops_seen = 0;
  int          truncs_seen = 0;
  int          drops_exp = 0;
  int          truncs_exp = 0;
  int          rd_mode = 0;
  bit          chk_gfm = 1'b0;
  logic [7:0]  msg[$];
  logic [16:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference model: a message either is refused (FIFO too full when it
  // starts) or becomes ceil(n/2) big-endian words, capped at MAXW words.
  task automatic model_msg(input logic [7:0] b[$]);
    int n  = b.size();
    int nw = (n + 1) / 2;
    if (exp_q.size() > DEPTH - MAXW) begin
      drops_exp++;
      return;
    end
    if (nw > MAXW) begin
      nw = MAXW;
      truncs_exp++;
    end
    for (int i = 0; i < nw; i++) begin
      logic [7:0] h = b[2*i];
      logic [7:0] l = (2*i + 1 < n) ? b[2*i+1] : PAD;
      exp_q.push_back({(i == nw - 1), h, l});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b[$], input bit eom, input bit gaps);
    foreach (b[i]) begin
      if (gaps) begin
        IN_VALID = 1'b0;
        IN_EOM   = 1'b0;
        idle($urandom_range(0, 2));
      end
      IN_DATA  = b[i];
      IN_VALID = 1'b1;
      IN_EOM   = eom && (i == b.size() - 1);
      idle(1);
    end
    IN_VALID = 1'b0;
    IN_EOM   = 1'b0;
  endtask

  task automatic make_msg(input int n);
    msg.delete();
    repeat (n) msg.push_back(8'($urandom));
  endtask

  task automatic q_check(input string tag);
    bit any_last = 1'b0;
    idle(4);
    foreach (exp_q[i]) if (exp_q[i][16]) any_last = 1'b1;
    check({tag, "_gfm"}, 32'(GOT_FULL_MSG), 32'(any_last));
    check({tag, "_empty"}, 32'(EMPTY), 32'(exp_q.size() == 0));
  endtask

  task automatic drain(input string tag, input bit gfm_on);
    int t = 0;
    chk_gfm = gfm_on;
    rd_mode = 1;
    while (!(exp_q.size() == 0 && EMPTY) && t < 5000) begin
      idle(1);
      t++;
    end
    rd_mode = 0;
    chk_gfm = 1'b0;
    if (t >= 5000) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d words still expected after 5000 cycles", tag, exp_q.size());
    end
    idle(3);
    check({tag, "_drained_empty"}, 32'(EMPTY), 32'(1));
    check({tag, "_drained_gfm"}, 32'(GOT_FULL_MSG), 32'(0));
  endtask

  // Read-request driver; offset from the input drive time so mode changes
  // made by the main sequence take effect in the same cycle.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      case (rd_mode)
        0:       RD_REQ = 1'b0;
        1:       RD_REQ = 1'b1;
        default: RD_REQ = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every accepted read consumes one expected word.
  always @(negedge CLK) begin
    if (RST) begin
      if (DROP)  drops_seen++;
      if (TRUNC) truncs_seen++;
      if (RD_REQ && !EMPTY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%0h, want no word", fifo_q);
        end else begin
          mon_e = exp_q.pop_front();
          check("fifo_q", 32'(fifo_q), 32'(mon_e[15:0]));
          if (chk_gfm) check("gfm_during_drain", 32'(GOT_FULL_MSG), 32'(1));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_empty", 32'(EMPTY), 32'(1));
    check("rst_gfm",   32'(GOT_FULL_MSG), 32'(0));
    check("rst_drop",  32'(DROP), 32'(0));
    check("rst_trunc", 32'(TRUNC), 32'(0));
    RST = 1'b1;
    idle(2);

    // Even message with latency checks
    msg = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_msg(msg);
    msg = '{8'h11, 8'h22};
    send(msg, 1'b0, 1'b0);
    @(negedge CLK);
    check("t1_not_early", 32'(EMPTY), 32'(1));
    @(posedge CLK);
    #1;
    check("t1_visible", 32'(EMPTY), 32'(0));
    check("t1_head", 32'(fifo_q), 32'(16'h1122));
    msg = '{8'h33, 8'h44};
    send(msg, 1'b1, 1'b0);
    check("t1_gfm_not_early", 32'(GOT_FULL_MSG), 32'(0));
    idle(1);
    check("t1_gfm_rise", 32'(GOT_FULL_MSG), 32'(1));
    drain("t1", 1'b1);

    // Odd message padded
    msg = '{8'hAA, 8'hBB, 8'hCC};
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    q_check("t2");
    drain("t2", 1'b1);

    // Two buffered messages streamed back to back
    make_msg(5);
    model_msg(msg);
    send(msg, 1'b1, 1'b1);
    make_msg(8);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    q_check("t3");
    drain("t3", 1'b1);

    // Admission threshold: 768 words buffered still admits, 769 refuses
    repeat (3) begin
      make_msg(2 * MAXW);
      model_msg(msg);
      send(msg, 1'b1, 1'b0);
    end
    make_msg(2);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    idle(3);
    make_msg(4);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    make_msg(1);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    q_check("t4");
    check("t4_drops", 32'(drops_seen), 32'(drops_exp));
    check("t4_truncs", 32'(truncs_seen), 32'(truncs_exp));
    drain("t4", 1'b1);

    // Truncation then a normal message
    make_msg(2 * MAXW + 6);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    make_msg(5);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    q_check("t5");
    check("t5_truncs", 32'(truncs_seen), 32'(truncs_exp));
    drain("t5", 1'b0);

    // Reset mid-message with five words buffered
    make_msg(4);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    make_msg(7);
    send(msg, 1'b0, 1'b0);
    idle(3);
    check("t6_pre_empty", 32'(EMPTY), 32'(0));
    check("t6_pre_gfm", 32'(GOT_FULL_MSG), 32'(1));
    RST = 1'b0;
    #1;
    check("t6_rst_empty", 32'(EMPTY), 32'(1));
    check("t6_rst_gfm", 32'(GOT_FULL_MSG), 32'(0));
    check("t6_rst_drop", 32'(DROP), 32'(0));
    check("t6_rst_trunc", 32'(TRUNC), 32'(0));
    exp_q.delete();
    idle(2);
    RST = 1'b1;
    idle(2);
    make_msg(9);
    model_msg(msg);
    send(msg, 1'b1, 1'b1);
    q_check("t6_fresh");
    drain("t6", 1'b1);

    // Read of a last-flagged word in the same cycle as a last-flagged write
    make_msg(2);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    idle(3);
    make_msg(2);
    model_msg(msg);
    send(msg, 1'b1, 1'b0);
    rd_mode = 1;
    idle(1);
    rd_mode = 0;
    idle(3);
    check("t7_gfm_kept", 32'(GOT_FULL_MSG), 32'(1));
    check("t7_nonempty", 32'(EMPTY), 32'(0));
    check("t7_remaining", 32'(exp_q.size()), 32'(1));
    drain("t7", 1'b1);

    // Randomized traffic with concurrent random reads
    rd_mode = 2;
    for (int m = 0; m < 25; m++) begin
      make_msg($urandom_range(1, 40));
      model_msg(msg);
      send(msg, 1'b1, 1'b1);
      idle($urandom_range(0, 3));
    end
    drain("rand", 1'b0);
    check("final_drops", 32'(drops_seen), 32'(drops_exp));
    check("final_truncs", 32'(truncs_seen), 32'(truncs_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
